// File: rtl/free_play_ctrl.sv
// free_play_ctrl: free-play front end for the organ.
// Every raw key and octave button is synchronised and debounced. The debounced
// buttons step a saturating octave register. The debounced keys drive a monophonic
// note tracker with last-pressed priority, legato fallback and optional timed sustain.
// All outputs are registered.
module free_play_ctrl #(
    parameter int NUM_KEYS       = 8,
    parameter int KEY_W          = 3,
    parameter int OCT_W          = 2,
    parameter int OCT_MAX        = 2,
    parameter int OCT_DEFAULT    = 1,
    parameter int DEB_CNT        = 100000,
    parameter int SUSTAIN_CYCLES = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_raw,
    input  logic                btn_up,
    input  logic                btn_center,
    input  logic                btn_down,
    input  logic                sustain_en,
    output logic [NUM_KEYS-1:0] note_vector,
    output logic [KEY_W-1:0]    note_idx,
    output logic                note_on,
    output logic                strike,
    output logic [OCT_W-1:0]    octave
);

    // Debounced inputs: keys in the low bits, then up, centre, down.
    localparam int NIN   = NUM_KEYS + 3;
    localparam int CNT_W = $clog2(DEB_CNT + 1);
    localparam int SUS_W = $clog2(SUSTAIN_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_SUS  = 2'd2;

    logic [NIN-1:0]      raw_all;
    logic [NIN-1:0]      sync1;
    logic [NIN-1:0]      sync2;
    logic [NIN-1:0]      stable;
    logic [NIN-1:0]      stable_d;
    logic [NIN-1:0]      rise;
    logic [CNT_W-1:0]    deb_cnt [NIN];
    logic                sus_sync1;
    logic                sus_sync2;

    logic [NUM_KEYS-1:0] key_rise;
    logic [NUM_KEYS-1:0] key_held;
    logic                up_rise;
    logic                ctr_rise;
    logic                dn_rise;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [KEY_W-1:0]    idx_next;
    logic                strike_next;
    logic [SUS_W-1:0]    sus_cnt;
    logic [SUS_W-1:0]    sus_next;
    logic [OCT_W-1:0]    oct_next;

    // Lowest set bit of a key vector; 0 when the vector is empty.
    function automatic logic [KEY_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
        logic [KEY_W-1:0] r;
        r = {KEY_W{1'b0}};
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = KEY_W'(i);
            end
        end
        return r;
    endfunction

    assign raw_all  = {btn_down, btn_center, btn_up, keys_raw};
    assign rise     = stable & ~stable_d;
    assign key_rise = rise[NUM_KEYS-1:0];
    assign key_held = stable[NUM_KEYS-1:0];
    assign up_rise  = rise[NUM_KEYS];
    assign ctr_rise = rise[NUM_KEYS+1];
    assign dn_rise  = rise[NUM_KEYS+2];

    // Two-flop synchronisers for every raw input, including sustain_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= {NIN{1'b0}};
            sync2     <= {NIN{1'b0}};
            sus_sync1 <= 1'b0;
            sus_sync2 <= 1'b0;
        end else begin
            sync1     <= raw_all;
            sync2     <= sync1;
            sus_sync1 <= sustain_en;
            sus_sync2 <= sus_sync1;
        end
    end

    // Per-input debounce: accept a new value only after DEB_CNT consecutive differing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable   <= {NIN{1'b0}};
            stable_d <= {NIN{1'b0}};
            for (int i = 0; i < NIN; i++) begin
                deb_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= {CNT_W{1'b0}};
                end else if (deb_cnt[i] == CNT_W'(DEB_CNT - 1)) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= {CNT_W{1'b0}};
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Next octave from debounced button edges; centre wins, up+down together cancel.
    always_comb begin
        oct_next = octave;
        if (ctr_rise) begin
            oct_next = OCT_W'(OCT_DEFAULT);
        end else if (up_rise && !dn_rise) begin
            if (octave == OCT_W'(OCT_MAX)) begin
                oct_next = octave;
            end else begin
                oct_next = octave + {{(OCT_W-1){1'b0}}, 1'b1};
            end
        end else if (dn_rise && !up_rise) begin
            if (octave == {OCT_W{1'b0}}) begin
                oct_next = octave;
            end else begin
                oct_next = octave - {{(OCT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            oct_next = octave;
        end
    end

    // Note tracker next state: a new key attack always wins, then legato, sustain and timeout.
    always_comb begin
        state_next  = state;
        idx_next    = note_idx;
        strike_next = 1'b0;
        sus_next    = sus_cnt;
        if (|key_rise) begin
            state_next  = ST_PLAY;
            idx_next    = lowest_idx(key_rise);
            strike_next = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_PLAY: begin
                    if (key_held[note_idx]) begin
                        state_next = ST_PLAY;
                    end else if (|key_held) begin
                        idx_next = lowest_idx(key_held);
                    end else if (sus_sync2) begin
                        state_next = ST_SUS;
                        sus_next   = SUS_W'(SUSTAIN_CYCLES - 1);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_SUS: begin
                    if (!sus_sync2) begin
                        state_next = ST_IDLE;
                    end else if (sus_cnt == {SUS_W{1'b0}}) begin
                        state_next = ST_IDLE;
                    end else begin
                        sus_next = sus_cnt - {{(SUS_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sus_cnt     <= {SUS_W{1'b0}};
            note_idx    <= {KEY_W{1'b0}};
            note_on     <= 1'b0;
            strike      <= 1'b0;
            note_vector <= {NUM_KEYS{1'b0}};
            octave      <= OCT_W'(OCT_DEFAULT);
        end else begin
            state    <= state_next;
            sus_cnt  <= sus_next;
            note_idx <= idx_next;
            strike   <= strike_next;
            octave   <= oct_next;
            if (state_next != ST_IDLE) begin
                note_on     <= 1'b1;
                note_vector <= {{(NUM_KEYS-1){1'b0}}, 1'b1} << idx_next;
            end else begin
                note_on     <= 1'b0;
                note_vector <= {NUM_KEYS{1'b0}};
            end
        end
    end

endmodule
